// File: rtl/img2col_map_seq.sv
// Image-to-column address sequencer: streams kernel-fill (BUFFER) beats, then
// working-round (WORK) beats, with a ready/valid handshake, abort, and a done pulse.
module img2col_map_seq #(
  parameter int KSIZE  = 5,
  parameter int NUM_PU = 28,
  parameter int ROUNDS = 28,
  parameter int AW     = ($clog2(KSIZE)  < 1) ? 1 : $clog2(KSIZE),
  parameter int PW     = ($clog2(NUM_PU) < 1) ? 1 : $clog2(NUM_PU),
  parameter int RW     = ($clog2(ROUNDS) < 1) ? 1 : $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [AW-1:0] pu_addr,
  output logic [PW-1:0] pu_no,
  output logic [AW-1:0] row_no,
  output logic [RW-1:0] round,
  output logic          working,
  output logic          row_last,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUFFER = 2'd1,
    S_WORK   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [AW-1:0] ADDR_LAST    = AW'(KSIZE - 1);
  localparam logic [AW-1:0] ROW_BUF_LAST = AW'(KSIZE - 2);
  localparam logic [AW-1:0] ROW_WORK     = AW'(KSIZE - 1);
  localparam logic [PW-1:0] PU_LAST      = PW'(NUM_PU - 1);
  localparam logic [RW-1:0] ROUND_LAST   = RW'(ROUNDS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pu_addr_q, pu_addr_d;
  logic [PW-1:0] pu_no_q, pu_no_d;
  logic [AW-1:0] row_no_q, row_no_d;
  logic [RW-1:0] round_q, round_d;
  logic          out_valid_q, out_valid_d;
  logic          working_q, working_d;
  logic          row_last_q, row_last_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  // Next-state, counter advance and registered-output decode.
  always_comb begin
    state_d   = state_q;
    pu_addr_d = pu_addr_q;
    pu_no_d   = pu_no_q;
    row_no_d  = row_no_q;
    round_d   = round_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_BUFFER;
          pu_addr_d = '0;
          pu_no_d   = '0;
          row_no_d  = '0;
          round_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUFFER, S_WORK: begin
        // abort wins over an accepted beat; the in-flight beat is dropped
        if (abort) begin
          state_d   = S_IDLE;
          pu_addr_d = '0;
          pu_no_d   = '0;
          row_no_d  = '0;
          round_d   = '0;
        end else if (out_ready) begin
          if (pu_addr_q != ADDR_LAST) begin
            pu_addr_d = pu_addr_q + AW'(1);
          end else begin
            pu_addr_d = '0;
            if (pu_no_q != PU_LAST) begin
              pu_no_d = pu_no_q + PW'(1);
            end else begin
              pu_no_d = '0;
              if (state_q == S_BUFFER) begin
                if (row_no_q == ROW_BUF_LAST) begin
                  state_d  = S_WORK;
                  row_no_d = ROW_WORK;
                  round_d  = '0;
                end else begin
                  row_no_d = row_no_q + AW'(1);
                end
              end else begin
                if (round_q == ROUND_LAST) begin
                  state_d  = S_DONE;
                  row_no_d = '0;
                  round_d  = '0;
                end else begin
                  round_d = round_q + RW'(1);
                end
              end
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        pu_addr_d = '0;
        pu_no_d   = '0;
        row_no_d  = '0;
        round_d   = '0;
      end
      default: begin
        state_d   = S_IDLE;
        pu_addr_d = '0;
        pu_no_d   = '0;
        row_no_d  = '0;
        round_d   = '0;
      end
    endcase

    out_valid_d = (state_d == S_BUFFER) || (state_d == S_WORK);
    working_d   = (state_d == S_WORK);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    row_last_d  = out_valid_d && (pu_no_d == PU_LAST) && (pu_addr_d == ADDR_LAST);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      pu_addr_q   <= '0;
      pu_no_q     <= '0;
      row_no_q    <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      working_q   <= 1'b0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pu_addr_q   <= pu_addr_d;
      pu_no_q     <= pu_no_d;
      row_no_q    <= row_no_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
      working_q   <= working_d;
      row_last_q  <= row_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pu_addr   = pu_addr_q;
  assign pu_no     = pu_no_q;
  assign row_no    = row_no_q;
  assign round     = round_q;
  assign working   = working_q;
  assign row_last  = row_last_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_img2col_map_seq.sv
// Bench for img2col_map_seq: default instance plus a small (3,5,6) instance,
// checked beat-by-beat against an arithmetic beat-index model.
module tb_img2col_map_seq;

  localparam int KA = 5, NA = 28, RA = 28;
  localparam int KB = 3, NB = 5, RB = 6;
  localparam logic [63:0] FLAG_MASK  = 64'h0000_001F_0000_0000;
  localparam logic [63:0] DONE_FLAGS = 64'h0000_0018_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, start_a, start_b, abort_a, out_ready;

  logic       valid_a, working_a, row_last_a, done_a, busy_a;
  logic [2:0] addr_a, row_a;
  logic [4:0] pu_a, round_a;

  logic       valid_b, working_b, row_last_b, done_b, busy_b;
  logic [1:0] addr_b, row_b;
  logic [2:0] pu_b, round_b;

  int checks = 0;
  int errors = 0;

  img2col_map_seq dut_a (
    .clk(clk), .nrst(nrst), .start(start_a), .abort(abort_a), .out_ready(out_ready),
    .out_valid(valid_a), .pu_addr(addr_a), .pu_no(pu_a), .row_no(row_a), .round(round_a),
    .working(working_a), .row_last(row_last_a), .done(done_a), .busy(busy_a)
  );

  img2col_map_seq #(.KSIZE(KB), .NUM_PU(NB), .ROUNDS(RB)) dut_b (
    .clk(clk), .nrst(nrst), .start(start_b), .abort(1'b0), .out_ready(out_ready),
    .out_valid(valid_b), .pu_addr(addr_b), .pu_no(pu_b), .row_no(row_b), .round(round_b),
    .working(working_b), .row_last(row_last_b), .done(done_b), .busy(busy_b)
  );

  function automatic logic [63:0] pack(input logic bz, input logic dn, input logic rl,
                                       input logic wk, input logic vl, input int rnd,
                                       input int row, input int pu, input int addr);
    return {27'd0, bz, dn, rl, wk, vl, rnd[7:0], row[7:0], pu[7:0], addr[7:0]};
  endfunction

  function automatic logic [63:0] obs(input int sel);
    if (sel == 0)
      return pack(busy_a, done_a, row_last_a, working_a, valid_a,
                  int'(round_a), int'(row_a), int'(pu_a), int'(addr_a));
    else
      return pack(busy_b, done_b, row_last_b, working_b, valid_b,
                  int'(round_b), int'(row_b), int'(pu_b), int'(addr_b));
  endfunction

  // Reference: the b-th accepted beat of a frame, from plain arithmetic.
  function automatic logic [63:0] exp_beat(input int b, input int k, input int n);
    int nbuf, w, rnd, row, pu, addr;
    logic wk;
    nbuf = (k - 1) * n * k;
    if (b < nbuf) begin
      wk = 1'b0; w = b; rnd = 0; row = b / (n * k);
    end else begin
      wk = 1'b1; w = b - nbuf; rnd = w / (n * k); row = k - 1;
    end
    pu   = (w / k) % n;
    addr = w % k;
    return pack(1'b1, 1'b0, (pu == n - 1) && (addr == k - 1), wk, 1'b1, rnd, row, pu, addr);
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // mode: 0 plain, 1 abort at beat `at`, 2 reset at beat `at`, 3 start held high
  task automatic run_frame(input int sel, input int stall, input int mode, input int at);
    int k, n, r, total, b, cyc;
    logic rdy;
    k = (sel == 0) ? KA : KB;
    n = (sel == 0) ? NA : NB;
    r = (sel == 0) ? RA : RB;
    total = (k - 1) * n * k + r * n * k;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    if (mode != 3) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    b = 0;
    cyc = 0;
    while (b < total && cyc < 20 * total) begin
      chk("beat", obs(sel), exp_beat(b, k, n));
      if (mode == 1 && b == at) begin
        abort_a = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_idle", obs(sel), 64'd0);
        @(negedge clk);
        chk("abort_no_done", obs(sel), 64'd0);
        return;
      end
      if (mode == 2 && b == at) begin
        nrst = 1'b0;
        start_a = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("reset_mid", obs(sel), 64'd0);
        nrst = 1'b1;
        start_a = 1'b0;
        @(negedge clk);
        chk("reset_stay_idle", obs(sel), 64'd0);
        return;
      end
      rdy = ($urandom_range(99) >= stall);
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) b++;
    end
    chk("beat_count", 64'(b), 64'(total));
    chk("done_pulse", obs(sel) & FLAG_MASK, DONE_FLAGS);
    @(negedge clk);
    if (mode == 3) begin
      chk("gap_idle", obs(sel), 64'd0);
      @(negedge clk);
      chk("restart_beat0", obs(sel), exp_beat(0, k, n));
      start_a = 1'b0;
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("restart_abort", obs(sel), 64'd0);
    end else begin
      chk("after_done_idle", obs(sel), 64'd0);
    end
  endtask

  initial begin
    nrst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    abort_a = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    chk("reset_a", obs(0), 64'd0);
    chk("reset_b", obs(1), 64'd0);
    start_a = 1'b0;
    start_b = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
    chk("idle_hold", obs(0), 64'd0);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_in_idle", obs(0), 64'd0);

    run_frame(0, 0, 0, 0);
    run_frame(0, 50, 0, 0);
    run_frame(0, 0, 1, (KA - 1) * NA * KA + 3 * NA * KA);
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 2, 100);
    run_frame(1, 50, 0, 0);
    run_frame(0, 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/img2col_map_seq.md
IMG2COL_MAP_SEQ -- requirements
Module: img2col_map_seq

Interface
REQ-001 The block SHALL take these parameters:
- KSIZE, 5, kernel size; PU address range 0..KSIZE-1; minimum 2.
- NUM_PU, 28, processing units per row sweep; minimum 1.
- ROUNDS, 28, working rounds per frame; minimum 1.
- AW, $clog2(KSIZE) (min 1), width of pu_addr and row_no.
- PW, $clog2(NUM_PU) (min 1), width of pu_no.
- RW, $clog2(ROUNDS) (min 1), width of round.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on its rising edge.
- nrst  in  1  reset; synchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  cancel the frame in progress.
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  the beat on pu_addr/pu_no/row_no/round is valid.
- pu_addr  out  AW  PU address within the kernel.
- pu_no  out  PW  PU index.
- row_no  out  AW  row index.
- round  out  RW  working round index.
- working  out  1  1 = WORK phase, 0 = BUFFER phase; meaningful only while out_valid=1.
- row_last  out  1  current beat is the last of a sweep.
- done  out  1  one-cycle pulse at frame completion.
- busy  out  1  state is not IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, BUFFER, WORK and DONE, with all outputs registered.
REQ-004 In IDLE with start=1, the next state SHALL be BUFFER with all counters at 0.
REQ-005 In IDLE with start=0, the block SHALL hold its state.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 out_valid SHALL be 1 in BUFFER and WORK and 0 in IDLE and DONE.
REQ-008 A beat SHALL be accepted on a cycle where out_valid=1 and out_ready=1.
REQ-009 Counters SHALL advance only on an accepted beat; when out_ready=0, all outputs SHALL hold unchanged.
REQ-010 Counter nesting SHALL be: pu_addr innermost (0..KSIZE-1), then pu_no (0..NUM_PU-1), then the outer counter.
REQ-011 The outer counter SHALL be row_no in BUFFER and round in WORK.
REQ-012 In BUFFER, row_no SHALL run 0..KSIZE-2, for (KSIZE-1)*NUM_PU*KSIZE beats in total.
REQ-013 On the accepted beat with row_no=KSIZE-2, pu_no=NUM_PU-1 and pu_addr=KSIZE-1, the block SHALL enter WORK with row_no=KSIZE-1, round=0, pu_no=0 and pu_addr=0.
REQ-014 In WORK, row_no SHALL stay at KSIZE-1, and each sweep (pu_addr/pu_no wrap) SHALL increment round.
REQ-015 The total number of WORK beats SHALL be ROUNDS*NUM_PU*KSIZE.
REQ-016 On the accepted beat with round=ROUNDS-1 and the sweep complete, the block SHALL enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE with all counters at 0.
REQ-018 row_last SHALL equal (pu_no==NUM_PU-1 && pu_addr==KSIZE-1) while out_valid=1, and SHALL be 0 otherwise.
REQ-019 working SHALL be 1 exactly in WORK.
REQ-020 busy SHALL be 1 in BUFFER, WORK and DONE.
REQ-021 Counter wraps SHALL be compare-to-limit, never power-of-two overflow, and SHALL hold for non-power-of-two parameters.
REQ-022 abort=1 in BUFFER or WORK SHALL force IDLE on the next edge, with counters cleared, done not asserted, and the in-flight beat discarded.
REQ-023 abort SHALL take priority over beat acceptance on the same cycle.
REQ-024 abort SHALL be ignored in IDLE and in DONE, where the done pulse still completes.
REQ-025 The block SHALL never hold out_valid=1 with a counter outside its legal range.

Reset
REQ-026 While nrst=0 at a rising edge, the next state SHALL be IDLE.
REQ-027 Reset SHALL clear pu_addr, pu_no, row_no, round, out_valid, working, row_last, done and busy to 0.
REQ-028 Reset SHALL override start, abort and out_ready, including mid-frame.
REQ-029 Reset SHALL be fully synchronous; no output may change except on a clk edge.

Verification
REQ-030 Defaults, out_ready=1 always, single-cycle start -> out_valid rises the next cycle; 560 BUFFER beats then 3920 WORK beats; done pulses once, exactly one cycle after the final beat (round=27, pu_no=27, pu_addr=4); busy falls the cycle after.
REQ-031 Random out_ready stalls (about 50%) -> outputs frozen while out_ready=0; the accepted-beat sequence is identical to REQ-030; 4480 beats total.
REQ-032 abort during WORK at round=3, with out_ready=1 on the same cycle -> next cycle IDLE, out_valid=0, counters 0, no done; a new start then replays from row_no=0.
REQ-033 nrst=0 asserted mid-BUFFER for one edge -> all outputs 0 and state IDLE after that edge; start pulses during reset have no effect.
REQ-034 KSIZE=3, NUM_PU=5, ROUNDS=6 -> 30 BUFFER beats (row_no 0..1), then 90 WORK beats with row_no=2; row_last every 15th beat; done after beat 120.
REQ-035 start held high continuously -> back-to-back frames, with exactly one IDLE cycle between DONE and the next BUFFER.
